// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle MIPS datapath: sequences fetch/decode/execute
// steps, drives every datapath strobe and takes interrupts at instruction boundaries.
module multicycle_controller #(
    parameter logic [31:0] RESET_PC_VECTOR = 32'h0
) (
    input  logic       clk,
    input  logic       rstN,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       irq,
    output logic [1:0] aluControl,
    output logic [1:0] aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] pcSource,
    output logic [1:0] regWrite,
    output logic [1:0] regDst,
    output logic [1:0] memToReg,
    output logic       isBranch,
    output logic       pcWrite,
    output logic       lorD,
    output logic       memWrite,
    output logic       IrWrite,
    output logic       isInterrupted,
    output logic       irqAck,
    output logic       illegalOp,
    output logic [3:0] stateOut
);
    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3, MEMWB = 4'd4,
        MEMWRITE = 4'd5, EXECUTE = 4'd6, ALUWB = 4'd7, BRANCH = 4'd8,
        ADDIEXEC = 4'd9, ADDIWB = 4'd10, JUMP = 4'd11, JAL = 4'd12, INTR = 4'd13
    } state_t;

    typedef struct packed {
        logic [1:0] aluControl;
        logic [1:0] aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] pcSource;
        logic [1:0] regWrite;
        logic [1:0] regDst;
        logic [1:0] memToReg;
        logic       isBranch;
        logic       pcWrite;
        logic       lorD;
        logic       memWrite;
        logic       IrWrite;
        logic       isInterrupted;
        logic       irqAck;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2b, OP_BEQ = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08, OP_J = 6'h02, OP_JAL = 6'h03;

    // The vector is only reachable through pcSource=11, which the datapath hardwires to zero.
    if (RESET_PC_VECTOR != 32'h0) begin : gVectorCheck
        $error("multicycle_controller: RESET_PC_VECTOR must be 0");
    end

    state_t state;
    ctrl_t  ctrl;
    logic   inService;

    function automatic logic functOk(input logic [5:0] f);
        return f == 6'h20 || f == 6'h22 || f == 6'h24 || f == 6'h25;
    endfunction

    function automatic logic legalInstr(input logic [5:0] o, input logic [5:0] f);
        case (o)
            OP_RTYPE:                                      return functOk(f);
            OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_JAL:   return 1'b1;
            default:                                       return 1'b0;
        endcase
    endfunction

    function automatic state_t nextStateFor(input state_t s, input logic [5:0] o,
                                            input logic [5:0] f, input logic rq,
                                            input logic svc);
        state_t endNext;
        endNext = (rq && !svc) ? INTR : FETCH;
        case (s)
            FETCH:    return DECODE;
            DECODE: begin
                if (!legalInstr(o, f)) return endNext;
                case (o)
                    OP_RTYPE:     return EXECUTE;
                    OP_LW, OP_SW: return MEMADR;
                    OP_BEQ:       return BRANCH;
                    OP_ADDI:      return ADDIEXEC;
                    OP_J:         return JUMP;
                    default:      return JAL;
                endcase
            end
            MEMADR:   return (o == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD:  return MEMWB;
            EXECUTE:  return ALUWB;
            ADDIEXEC: return ADDIWB;
            default:  return endNext;
        endcase
    endfunction

    function automatic ctrl_t ctrlFor(input state_t s, input logic [5:0] f);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH:    begin c.IrWrite = 1'b1; c.aluSrcB = 2'b01; c.pcWrite = 1'b1; end
            DECODE:   c.aluSrcB = 2'b11;
            MEMADR, ADDIEXEC: begin c.aluSrcA = 2'b01; c.aluSrcB = 2'b10; end
            MEMREAD:  c.lorD = 1'b1;
            MEMWB:    begin c.memToReg = 2'b01; c.regWrite = 2'b01; end
            MEMWRITE: begin c.lorD = 1'b1; c.memWrite = 1'b1; end
            EXECUTE: begin
                c.aluSrcA = 2'b01;
                case (f)
                    6'h22:   c.aluControl = 2'b01;
                    6'h24:   c.aluControl = 2'b10;
                    6'h25:   c.aluControl = 2'b11;
                    default: c.aluControl = 2'b00;
                endcase
            end
            ALUWB:    begin c.regDst = 2'b01; c.regWrite = 2'b01; end
            ADDIWB:   c.regWrite = 2'b01;
            BRANCH: begin
                c.aluSrcA = 2'b01; c.aluControl = 2'b01; c.pcSource = 2'b01; c.isBranch = 1'b1;
            end
            JUMP:     begin c.pcSource = 2'b10; c.pcWrite = 1'b1; end
            JAL: begin
                c.pcSource = 2'b10; c.pcWrite = 1'b1;
                c.regDst = 2'b10; c.memToReg = 2'b10; c.regWrite = 2'b01;
            end
            INTR: begin
                c.isInterrupted = 1'b1; c.irqAck = 1'b1;
                c.regDst = 2'b10; c.memToReg = 2'b10; c.regWrite = 2'b01;
                c.pcSource = 2'b11; c.pcWrite = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // Outputs are registered from the next state so they line up with stateOut.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state     <= FETCH;
            inService <= 1'b0;
            ctrl      <= ctrlFor(FETCH, 6'h00);
        end else begin
            state <= nextStateFor(state, op, funct, irq, inService);
            ctrl  <= ctrlFor(nextStateFor(state, op, funct, irq, inService), funct);
            if (nextStateFor(state, op, funct, irq, inService) == INTR) inService <= 1'b1;
            else if (!irq)                                               inService <= 1'b0;
        end
    end

    // Write strobes are gated by reset so an abort is visible without waiting for a clock.
    assign aluControl    = ctrl.aluControl;
    assign aluSrcA       = ctrl.aluSrcA;
    assign aluSrcB       = ctrl.aluSrcB;
    assign pcSource      = ctrl.pcSource;
    assign regWrite      = ctrl.regWrite & {2{rstN}};
    assign regDst        = ctrl.regDst;
    assign memToReg      = ctrl.memToReg;
    assign isBranch      = ctrl.isBranch & rstN;
    assign pcWrite       = ctrl.pcWrite & rstN;
    assign lorD          = ctrl.lorD;
    assign memWrite      = ctrl.memWrite & rstN;
    assign IrWrite       = ctrl.IrWrite & rstN;
    assign isInterrupted = ctrl.isInterrupted;
    assign irqAck        = ctrl.irqAck & rstN;
    // The IR loads on the edge leaving FETCH, so the illegal check must look at op live.
    assign illegalOp     = rstN && state == DECODE && !legalInstr(op, funct);
    assign stateOut      = state;
endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: expected state/output records are queued
// as each instruction is issued and compared cycle by cycle.
module tb_multicycle_controller;
    logic       clk = 1'b0;
    logic       rstN;
    logic [5:0] op, funct;
    logic       irq;
    logic [1:0] aluControl, aluSrcA, aluSrcB, pcSource, regWrite, regDst, memToReg;
    logic       isBranch, pcWrite, lorD, memWrite, IrWrite, isInterrupted, irqAck, illegalOp;
    logic [3:0] stateOut;
    logic [21:0] dutVec;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] st;
        logic [5:0] op;
        logic [5:0] fn;
    } exp_t;
    exp_t sb[$];

    localparam logic [21:0] RESET_VEC = {4'b0000, 2'b01, 16'h0000};

    multicycle_controller dut (
        .clk(clk), .rstN(rstN), .op(op), .funct(funct), .irq(irq),
        .aluControl(aluControl), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .pcSource(pcSource),
        .regWrite(regWrite), .regDst(regDst), .memToReg(memToReg), .isBranch(isBranch),
        .pcWrite(pcWrite), .lorD(lorD), .memWrite(memWrite), .IrWrite(IrWrite),
        .isInterrupted(isInterrupted), .irqAck(irqAck), .illegalOp(illegalOp),
        .stateOut(stateOut)
    );

    always #5 clk = ~clk;

    assign dutVec = {aluControl, aluSrcA, aluSrcB, pcSource, regWrite, regDst, memToReg,
                     isBranch, pcWrite, lorD, memWrite, IrWrite, isInterrupted, irqAck, illegalOp};

    function automatic logic legal(input logic [5:0] o, input logic [5:0] f);
        if (o == 6'h00) return f == 6'h20 || f == 6'h22 || f == 6'h24 || f == 6'h25;
        return o == 6'h23 || o == 6'h2b || o == 6'h04 || o == 6'h08 || o == 6'h02 || o == 6'h03;
    endfunction

    // Expected outputs per state, written straight from the state/output table.
    function automatic logic [21:0] expVec(input logic [3:0] s, input logic [5:0] o,
                                           input logic [5:0] f);
        logic [1:0] aC, aA, aB, pS, rW, rD, mR;
        logic br, pW, lD, mW, iW, iI, iA, il;
        {aC, aA, aB, pS, rW, rD, mR} = '0;
        {br, pW, lD, mW, iW, iI, iA, il} = '0;
        case (s)
            4'd0:  begin iW = 1; aB = 2'b01; pW = 1; end
            4'd1:  begin aB = 2'b11; il = !legal(o, f); end
            4'd2, 4'd9: begin aA = 2'b01; aB = 2'b10; end
            4'd3:  lD = 1;
            4'd4:  begin mR = 2'b01; rW = 2'b01; end
            4'd5:  begin lD = 1; mW = 1; end
            4'd6:  begin
                aA = 2'b01;
                aC = (f == 6'h22) ? 2'b01 : (f == 6'h24) ? 2'b10 : (f == 6'h25) ? 2'b11 : 2'b00;
            end
            4'd7:  begin rD = 2'b01; rW = 2'b01; end
            4'd8:  begin aA = 2'b01; aC = 2'b01; pS = 2'b01; br = 1; end
            4'd10: rW = 2'b01;
            4'd11: begin pS = 2'b10; pW = 1; end
            4'd12: begin pS = 2'b10; pW = 1; rD = 2'b10; mR = 2'b10; rW = 2'b01; end
            4'd13: begin
                iI = 1; iA = 1; rD = 2'b10; mR = 2'b10; rW = 2'b01; pS = 2'b11; pW = 1;
            end
            default: ;
        endcase
        return {aC, aA, aB, pS, rW, rD, mR, br, pW, lD, mW, iW, iI, iA, il};
    endfunction

    task automatic checkNow(input string tag, input logic [3:0] st, input logic [21:0] vec);
        checks++;
        assert (stateOut === st) else begin
            failures++;
            $error("FAIL %s state observed=%0d expected=%0d", tag, stateOut, st);
        end
        checks++;
        assert (dutVec === vec) else begin
            failures++;
            $error("FAIL %s outputs observed=%h expected=%h (state %0d)", tag, dutVec, vec, st);
        end
    endtask

    task automatic push(input logic [3:0] st);
        exp_t e;
        e.st = st; e.op = op; e.fn = funct;
        sb.push_back(e);
    endtask

    task automatic drain(input string tag);
        exp_t e;
        while (sb.size() > 0) begin
            @(posedge clk); #1;
            e = sb.pop_front();
            checkNow(tag, e.st, expVec(e.st, e.op, e.fn));
        end
    endtask

    task automatic issue(input logic [5:0] o, input logic [5:0] f);
        op = o; funct = f;
    endtask

    initial begin
        rstN = 1'b0; op = '0; funct = '0; irq = 1'b0;
        repeat (2) @(posedge clk);
        #1 checkNow("reset", 4'd0, RESET_VEC);
        @(negedge clk) rstN = 1'b1;
        #1 checkNow("fetch_after_reset", 4'd0, expVec(4'd0, 6'h00, 6'h00));

        issue(6'h23, 6'h00); push(1); push(2); push(3); push(4); push(0); drain("lw");
        issue(6'h00, 6'h22); push(1); push(6); push(7); push(0); drain("rtype_sub");
        issue(6'h04, 6'h00); push(1); push(8); push(0); drain("beq");
        issue(6'h03, 6'h00); push(1); push(12); push(0); drain("jal");
        issue(6'h00, 6'h25); push(1); push(6); push(7); push(0); drain("rtype_or");

        // irq rises during EXECUTE: taken once after ALUWB.
        issue(6'h00, 6'h20); push(1); push(6); drain("irq_add");
        irq = 1'b1; push(7); push(13); push(0); drain("irq_take");
        issue(6'h2b, 6'h00); push(1); push(2); push(5); push(0); drain("sw_irq_held");
        irq = 1'b0; issue(6'h02, 6'h00); push(1); drain("j_irq_low");
        irq = 1'b1; push(11); push(13); push(0); drain("j_irq_retake");
        irq = 1'b0;

        issue(6'h08, 6'h00); push(1); push(9); push(10); push(0); drain("addi");
        issue(6'h3f, 6'h00); push(1); push(0); drain("illegal_op");
        issue(6'h00, 6'h3f); push(1); push(0); drain("illegal_funct");
        issue(6'h00, 6'h24); push(1); push(6); push(7); push(0); drain("rtype_and");

        // Reset asserted in MEMREAD aborts immediately.
        issue(6'h23, 6'h00); push(1); push(2); push(3); drain("lw_abort");
        rstN = 1'b0;
        #1 checkNow("reset_mid_instr", 4'd0, RESET_VEC);
        @(negedge clk) rstN = 1'b1;
        #1 checkNow("fetch_after_abort", 4'd0, expVec(4'd0, 6'h00, 6'h00));
        issue(6'h02, 6'h00); push(1); push(11); push(0); drain("j_after_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
